// File: rtl/stream_max_min.sv
`default_nettype none
// ============================================================================
//  Module      : stream_max_min
//  Description : Collects a frame of FRAME_LEN samples over a valid/ready
//                stream, tracks the running maximum and minimum together
//                with the frame position of their first occurrence, and
//                presents the results through an output valid/ready handshake.
//  Revision    : 1.0 - initial sequential release
// ============================================================================
module stream_max_min #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 4,
    parameter int SIGNED    = 0,
    parameter int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] min_val,
    output logic [IDX_W-1:0] max_idx,
    output logic [IDX_W-1:0] min_idx,
    output logic             busy
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_collect = 2'd1;
    localparam logic [1:0] c_done    = 2'd2;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(FRAME_LEN - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [IDX_W-1:0] r_count;
    logic             w_accept;
    logic             w_last;
    logic             w_gt;
    logic             w_lt;

    // in_ready is a pure decode of the state flop, so no input reaches it
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_count == c_last_idx);

    // Sample-vs-extreme comparators; signedness fixed at elaboration
    generate
        if (SIGNED != 0) begin : g_cmp_signed
            assign w_gt = $signed(in_data) > $signed(max_val);
            assign w_lt = $signed(in_data) < $signed(min_val);
        end else begin : g_cmp_unsigned
            assign w_gt = in_data > max_val;
            assign w_lt = in_data < min_val;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start only counts in IDLE, results leave on handshake
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_next_state = c_collect;
                end
            end
            c_collect: begin
                if (w_accept && w_last) begin
                    w_next_state = c_done;
                end
            end
            c_done: begin
                if (out_ready) begin
                    w_next_state = c_idle;
                end
            end
            default: begin
                w_next_state = c_idle;
            end
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            c_collect: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            c_done: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Sample counter: cleared on start, held at the last index once the frame fills
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if ((r_state == c_idle) && start) begin
            r_count <= '0;
        end else if (w_accept && !w_last) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Extreme tracking: first sample seeds both, strict compares keep earliest index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val <= '0;
            min_val <= '0;
            max_idx <= '0;
            min_idx <= '0;
        end else if (w_accept) begin
            if (r_count == '0) begin
                max_val <= in_data;
                min_val <= in_data;
                max_idx <= '0;
                min_idx <= '0;
            end else begin
                if (w_gt) begin
                    max_val <= in_data;
                    max_idx <= r_count;
                end
                if (w_lt) begin
                    min_val <= in_data;
                    min_idx <= r_count;
                end
            end
        end
    end

endmodule
`default_nettype wire
